// File: rtl/lamp_pkg.sv
// Shared lamp constants: channels per LED board and frame geometry helpers.
// Used by the frame loader, framebuffer and driver so all agree on sizing.
// Pure constants and functions; no logic.
package lamp_pkg;

  localparam int c_channels_per_board = 32;

  // Words per frame for a given number of LED boards.
  function automatic int f_channels(input int ledboards);
    return ledboards * c_channels_per_board;
  endfunction

  // Framebuffer address width for a given number of LED boards.
  function automatic int f_addr_w(input int ledboards);
    return $clog2(f_channels(ledboards));
  endfunction

endpackage

// File: rtl/spi_frame_loader_sync_edge.sv
// Multi-flop synchronisers for asynchronous serial-link inputs.
// Latency: c_stages cycles; sync_edge adds a registered rising-edge detect.
// No backpressure: inputs are sampled every cycle.

module sync_bits #(
  parameter int c_width  = 1,
  parameter int c_stages = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_width-1:0] d,
  output logic [c_width-1:0] q
);

  logic [c_stages-1:0][c_width-1:0] stg;

  // Shift the asynchronous inputs through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg <= '0;
    end else begin
      stg <= {stg[c_stages-2:0], d};
    end
  end

  assign q = stg[c_stages-1];

endmodule

module sync_edge #(
  parameter int c_stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_s;
  logic d_prev;

  sync_bits #(.c_width(1), .c_stages(c_stages)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .q     (d_s)
  );

  // Remember the previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_prev <= 1'b0;
    end else begin
      d_prev <= d_s;
    end
  end

  assign rise = d_s & ~d_prev;

endmodule

// File: rtl/spi_frame_loader.sv
// Deserialises one SPI frame of c_bps-bit words into framebuffer writes at 0..c_channels-1.
// Latency: write strobe one cycle after the synchronised sclk rise completing a word.
// No backpressure: the framebuffer accepts every write; extra words set an overflow flag.
module spi_frame_loader
  import lamp_pkg::*;
#(
  parameter  int c_ledboards   = 2,
  parameter  int c_bps         = 12,
  parameter  int c_sync_stages = 2,
  localparam int c_channels    = f_channels(c_ledboards),
  localparam int c_addr_w      = f_addr_w(c_ledboards)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sclk,
  input  logic                i_mosi,
  input  logic                i_cs_n,
  output logic                o_wen,
  output logic [c_addr_w-1:0] o_waddr,
  output logic [c_bps-1:0]    o_wdata,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_frame_err
);

  localparam int c_bit_w = $clog2(c_bps);
  localparam int c_cnt_w = c_addr_w + 1;
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_bps - 1);
  localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(c_channels);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_RECV,
    S_FULL,
    S_END
  } state_t;

  state_t               state;
  logic                 sclk_rise;
  logic [1:0]           ctl_s;
  logic                 mosi_s;
  logic                 cs_n_s;
  logic [c_bps-2:0]     shift;
  logic [c_bit_w-1:0]   bit_cnt;
  logic [c_cnt_w-1:0]   word_cnt;
  logic                 ovf;
  logic                 frame_ok;

  sync_edge #(.c_stages(c_sync_stages)) u_sclk_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (i_sclk),
    .rise  (sclk_rise)
  );

  sync_bits #(.c_width(2), .c_stages(c_sync_stages)) u_ctl_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     ({i_mosi, i_cs_n}),
    .q     (ctl_s)
  );

  assign mosi_s = ctl_s[1];
  assign cs_n_s = ctl_s[0];

  // A frame is good only if it ended exactly on the last word with nothing extra.
  assign frame_ok = (word_cnt == c_full) && (bit_cnt == '0) && !ovf;

  // Frame FSM: word assembly, write strobes and end-of-frame status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_WAIT_HIGH;
      shift        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      ovf          <= 1'b0;
      o_wen        <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_wen        <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      unique case (state)
        // cs_n held low across reset release must not start a frame.
        S_WAIT_HIGH: begin
          if (cs_n_s) state <= S_IDLE;
        end
        S_IDLE: begin
          if (!cs_n_s) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            ovf      <= 1'b0;
            o_busy   <= 1'b1;
            state    <= S_RECV;
          end
        end
        // cs_n deassert takes priority over a coincident sclk rise.
        S_RECV: begin
          if (cs_n_s) begin
            o_busy       <= 1'b0;
            o_frame_done <= frame_ok;
            o_frame_err  <= !frame_ok;
            state        <= S_END;
          end else if (sclk_rise) begin
            shift <= {shift[c_bps-3:0], mosi_s};
            if (bit_cnt == c_last_bit) begin
              o_wen    <= 1'b1;
              o_wdata  <= {shift, mosi_s};
              o_waddr  <= word_cnt[c_addr_w-1:0];
              bit_cnt  <= '0;
              word_cnt <= word_cnt + 1'b1;
              if (word_cnt + 1'b1 == c_full) state <= S_FULL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        // Frame already complete; any further clocking is an overflow.
        S_FULL: begin
          if (cs_n_s) begin
            o_busy       <= 1'b0;
            o_frame_done <= frame_ok;
            o_frame_err  <= !frame_ok;
            state        <= S_END;
          end else if (sclk_rise) begin
            ovf <= 1'b1;
          end
        end
        S_END: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_WAIT_HIGH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Self-checking bench for spi_frame_loader: random and patterned frames vs a bit-count model.
// Frames are driven bit by bit over the serial link with legal phase lengths.
// Writes and status pulses are collected by a monitor and compared per frame.
module tb_spi_frame_loader;

  localparam int BPS  = 12;
  localparam int CH   = 64;
  localparam int HALF = 4;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_sclk  = 1'b0;
  logic        i_mosi  = 1'b0;
  logic        i_cs_n  = 1'b1;
  logic        o_wen;
  logic [5:0]  o_waddr;
  logic [11:0] o_wdata;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_frame_err;

  always #5 i_clk = ~i_clk;

  spi_frame_loader #(.c_ledboards(2), .c_bps(12), .c_sync_stages(2)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sclk       (i_sclk),
    .i_mosi       (i_mosi),
    .i_cs_n       (i_cs_n),
    .o_wen        (o_wen),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  typedef struct packed {
    logic [5:0]  a;
    logic [11:0] d;
  } wr_t;

  wr_t wq[$];
  int  done_cnt = 0;
  int  err_cnt  = 0;
  int  both_cnt = 0;
  int  checks   = 0;
  int  failures = 0;
  logic [11:0] fr[$];

  // Collect every framebuffer write and status pulse.
  always @(negedge i_clk) begin
    if (o_wen) wq.push_back('{a: o_waddr, d: o_wdata});
    if (o_frame_done) done_cnt <= done_cnt + 1;
    if (o_frame_err) err_cnt <= err_cnt + 1;
    if (o_frame_done && o_frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // One mode-0 bit; optionally raise cs_n together with the sampling edge.
  task automatic send_bit(input logic b, input bit with_cs);
    i_mosi = b;
    tick(HALF);
    i_sclk = 1'b1;
    if (with_cs) i_cs_n = 1'b1;
    tick(HALF);
    i_sclk = 1'b0;
  endtask

  task automatic make_frame(input int nwords, input bit pattern);
    fr.delete();
    for (int k = 0; k < nwords; k++)
      fr.push_back(pattern ? 12'((k * 'h41) & 'hFFF) : 12'($urandom_range(0, 4095)));
  endtask

  function automatic logic frame_bit(input int b);
    logic [11:0] w;
    w = fr[b / BPS];
    return w[BPS - 1 - (b % BPS)];
  endfunction

  // Model: only bits actually delivered count; complete words become writes up to CH,
  // and the frame is good only if exactly CH*BPS bits arrived.
  task automatic run_frame(input string tag, input int n_bits, input bit coincide,
                           input bit pattern, input int gap);
    int start, d0, e0, delivered, exp_w, got, n_cmp;
    bit exp_done;
    make_frame((n_bits + BPS - 1) / BPS, pattern);
    start = wq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    i_cs_n = 1'b0;
    tick(4);
    for (int b = 0; b < n_bits; b++) begin
      send_bit(frame_bit(b), coincide && (b == n_bits - 1));
      if (b == 2 * BPS) chk({tag, "_busy_mid"}, 32'(o_busy), 32'd1);
    end
    i_cs_n = 1'b1;
    tick(gap);
    delivered = coincide ? n_bits - 1 : n_bits;
    exp_w = (delivered / BPS > CH) ? CH : delivered / BPS;
    exp_done = (delivered == CH * BPS);
    got = wq.size() - start;
    chk({tag, "_nwrites"}, 32'(got), 32'(exp_w));
    n_cmp = (got < exp_w) ? got : exp_w;
    for (int i = 0; i < n_cmp; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wq[start + i].a), 32'(i));
      chk($sformatf("%s_data%0d", tag, i), 32'(wq[start + i].d), 32'(fr[i]));
    end
    chk({tag, "_done"}, 32'(done_cnt - d0), exp_done ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(err_cnt - e0), exp_done ? 32'd0 : 32'd1);
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int s, d0, e0;

    // Reset state.
    tick(3);
    chk("rst_wen", 32'(o_wen), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_waddr", 32'(o_waddr), 32'd0);
    chk("rst_wdata", 32'(o_wdata), 32'd0);
    chk("rst_done", 32'(o_frame_done), 32'd0);
    chk("rst_err", 32'(o_frame_err), 32'd0);
    i_rst_n = 1'b1;
    tick(6);

    run_frame("full", CH * BPS, 1'b0, 1'b1, 8);
    run_frame("short", 10 * BPS + 5, 1'b0, 1'b0, 8);
    run_frame("ovf", (CH + 1) * BPS, 1'b0, 1'b0, 8);

    // Reset in the middle of a frame, released with cs_n still low.
    make_frame(24, 1'b0);
    i_cs_n = 1'b0;
    tick(4);
    for (int b = 0; b < 20 * BPS; b++) send_bit(frame_bit(b), 1'b0);
    tick(2);
    i_rst_n = 1'b0;
    tick(2);
    chk("midrst_wen", 32'(o_wen), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    chk("midrst_waddr", 32'(o_waddr), 32'd0);
    chk("midrst_wdata", 32'(o_wdata), 32'd0);
    s = wq.size();
    d0 = done_cnt;
    e0 = err_cnt;
    i_rst_n = 1'b1;
    for (int b = 0; b < 2 * BPS; b++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    chk("postrst_busy", 32'(o_busy), 32'd0);
    chk("postrst_nwrites", 32'(wq.size() - s), 32'd0);
    i_cs_n = 1'b1;
    tick(6);
    chk("postrst_done", 32'(done_cnt - d0), 32'd0);
    chk("postrst_err", 32'(err_cnt - e0), 32'd0);
    run_frame("after_rst", CH * BPS, 1'b0, 1'b0, 8);

    run_frame("coincide", CH * BPS, 1'b1, 1'b0, 8);

    run_frame("b2b_a", CH * BPS, 1'b0, 1'b0, 4);
    run_frame("b2b_b", CH * BPS, 1'b0, 1'b0, 8);

    chk("done_err_together", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Host-side writer for the LED framebuffer.
- Receives one frame of channel intensities from an external MCU over a mode-0 SPI-style link (i_sclk, i_mosi, i_cs_n), sampled in the i_clk domain.
- Deserialises c_bps-bit words and writes them to the framebuffer write port (wen/waddr/wdata) at consecutive addresses starting at 0.
- Reports frame completion or a framing error; the driver then shifts the stored frame out to the LED boards.

Parameters:
c_ledboards, 2, number of LED boards; 32 channels per board
c_bps, 12, bits per channel word
c_sync_stages, 2, synchroniser depth for i_sclk/i_mosi/i_cs_n (minimum 2)
c_channels, c_ledboards*32, derived: words per frame
c_addr_w, $clog2(c_channels), derived: address width

Ports:
i_clk  in  1  system clock (lamp w_clk domain)
i_rst_n  in  1  asynchronous active-low reset
i_sclk  in  1  serial clock from host, asynchronous; high and low phases each ≥ c_sync_stages+2 i_clk cycles
i_mosi  in  1  serial data, MSB first, stable around rising i_sclk
i_cs_n  in  1  frame select, active low, asynchronous
o_wen  out  1  framebuffer write strobe, one-cycle pulse
o_waddr  out  c_addr_w  framebuffer write address
o_wdata  out  c_bps  framebuffer write data
o_busy  out  1  high while in RECV or FULL
o_frame_done  out  1  one-cycle pulse: exactly c_channels words received
o_frame_err  out  1  one-cycle pulse: frame ended short, with a partial word, or overflowed

Behaviour:
- Reset (async assert, sync release): all outputs 0; state WAIT_HIGH; shift register, bit counter, word counter and synchroniser flops all 0.
- Synchronisation: i_sclk, i_mosi and i_cs_n each pass through c_sync_stages flops. One further register on synced sclk detects rising edges (sclk_rise). cs_n level is the synced value.
- States:
  - WAIT_HIGH: wait for synced cs_n = 1, then go to IDLE. A cs_n held low across reset release is never treated as a frame.
  - IDLE: on synced cs_n = 0, clear bit/word counters and go to RECV.
  - RECV:
    - On each sclk_rise: shift synced mosi into the LSB; increment the bit counter.
    - On the sclk_rise that completes bit c_bps: register outputs at that same edge: o_wen=1, o_wdata = {shift[c_bps-2:0], mosi}, o_waddr = word counter. So o_wen is high in the cycle after the sclk_rise is detected. Then clear the bit counter and increment the word counter.
    - When the word counter reaches c_channels, go to FULL.
  - FULL: any sclk_rise sets an internal overflow flag; no writes occur.
  - END: entered from RECV or FULL when synced cs_n = 1. Lasts one cycle, then IDLE.
    - Pulse o_frame_done if word counter = c_channels, bit counter = 0 and no overflow.
    - Otherwise pulse o_frame_err.
    - Done and err are never high together.
- Writes: o_wen high for exactly one cycle per word. o_waddr and o_wdata hold their last values when o_wen is low. Addresses are strictly 0..c_channels-1 and never wrap within a frame.
- Simultaneous sclk_rise and cs_n deassert in the same synced cycle: cs_n wins; the bit is dropped and END is entered.
- Partial word at cs_n deassert: discarded, no write, o_frame_err.
- Reset mid-frame: abort immediately; a partial frame already written remains in the framebuffer; state returns to WAIT_HIGH.
- Word counter width is c_addr_w+1 so that the value c_channels is representable.

Decomposition:
- Shared package/header lamp_pkg: c_channels_per_board=32, and the derivation formulas for c_channels and c_addr_w. These are shared with framebuffer and driver.
- State encoding as localparams local to the module.
- One natural sub-module: sync_edge (c_sync_stages-deep synchroniser plus rising-edge detector), instantiated for sclk; the same synchroniser without edge output is used for mosi and cs_n.

Test Plan:
- Full frame, c_ledboards=2: 64 words, word k = (k*0x41)&0xFFF → 64 o_wen pulses, waddr 0..63, wdata matches; then cs_n high → one o_frame_done, no o_frame_err.
- Short frame: 10 words plus 5 bits, then cs_n high → exactly 10 writes (addr 0..9), o_frame_err pulse, no o_frame_done.
- Overflow: 65 words → 64 writes only, last write addr 63 data = word 63; o_frame_err at end.
- Reset mid-frame: assert i_rst_n=0 after word 20 with cs_n still low, release with cs_n low → no writes until cs_n goes high then low; the next full frame completes with o_frame_done and addr starting at 0.
- Edge coincidence: final sclk rise of word 63 arrives in the same synced cycle as cs_n rise → 63 writes, o_frame_err.
- Back-to-back frames separated by 4 cycles of cs_n high → two o_frame_done pulses; second frame's writes restart at addr 0 and match its data.
